fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the first fetch address after reset; bits [1:0] SHALL be treated as 0.
REQ-002 Parameter QDEPTH, default 4, SHALL set the instruction queue depth; legal values are powers of two, at least 2.
REQ-003 One clock; reset is synchronous and active-high (ports clk, reset).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 mem_req_valid  output  1  read request to instruction memory.
REQ-007 mem_req_addr  output  64  doubleword-aligned request address; bits [2:0] SHALL always be 0.
REQ-008 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 mem_resp_valid  input  1  read data valid.
REQ-010 mem_resp_data  input  64  two instructions: [31:0] at addr+0, [63:32] at addr+4.
REQ-011 redirect_valid  input  1  branch/jump redirect from execute.
REQ-012 redirect_pc  input  64  redirect target; bits [1:0] ignored.
REQ-013 IFID_instreg  output  32  instruction at the queue head.
REQ-014 IFID_npc  output  64  head instruction PC + 4.
REQ-015 IFID_ready  output  1  head entry valid, i.e. queue not empty.
REQ-016 ID_stall  input  1  decode cannot accept this cycle.

Function
REQ-017 fetch_pc register SHALL hold the next instruction address to request; fetch_pc[2] selects the starting half of each doubleword.
REQ-018 FSM states SHALL be IDLE, REQ, WAIT and DISCARD.
REQ-019 IDLE -> REQ when the queue has at least 2 free entries, counting entries freed by a same-cycle pop.
REQ-020 REQ: mem_req_valid=1 and mem_req_addr={fetch_pc[63:3],3'b000}; on mem_req_ready go to WAIT.
REQ-021 Only one request SHALL be outstanding at a time.
REQ-022 WAIT: on mem_resp_valid, enqueue the lower word (only if fetch_pc[2]=0) then the upper word, in order.
REQ-023 Each enqueued entry SHALL store {instr, pc+4}.
REQ-024 After the WAIT enqueue, fetch_pc SHALL become {fetch_pc[63:3]+1,3'b000} and the FSM SHALL go to IDLE.
REQ-025 Pop SHALL occur when IFID_ready=1 and ID_stall=0; IFID_instreg/IFID_npc then show the next entry on the following cycle.
REQ-026 A same-cycle pop and enqueue SHALL both take effect.
REQ-027 The queue SHALL never overflow (guaranteed by REQ-019); the head and tail pointers SHALL wrap modulo QDEPTH.
REQ-028 Redirect (any state) SHALL flush the queue and set fetch_pc=redirect_pc with bits [1:0]=0; IFID_ready=0 next cycle.
REQ-029 Redirect has priority over a same-cycle pop and enqueue; both are discarded.
REQ-030 Redirect in IDLE or REQ SHALL go to REQ, presenting the new address next cycle.
REQ-031 Redirect in REQ while mem_req_ready=1 in the same cycle: the accepted request is stale, so go to DISCARD.
REQ-032 Redirect in WAIT without mem_resp_valid SHALL go to DISCARD.
REQ-033 Redirect in WAIT with mem_resp_valid in the same cycle SHALL drop the data and go to REQ.
REQ-034 DISCARD SHALL drop the next mem_resp_valid data, then go to REQ.
REQ-035 A further redirect in DISCARD SHALL update fetch_pc only and remain in DISCARD.
REQ-036 Minimum latency SHALL be: request accepted in cycle N, response in N+1, IFID_ready=1 in N+2.

Reset
REQ-037 While reset=1: mem_req_valid=0, mem_req_addr=0, IFID_ready=0, IFID_instreg=0, IFID_npc=0, queue empty, fetch_pc=RESET_PC, state IDLE.
REQ-038 Reset mid-transaction SHALL abandon the outstanding request without entering DISCARD; memory is reset together with this block.
REQ-039 The first mem_req_valid SHALL assert in the second cycle after reset deasserts.

Verification
REQ-040 Reset, RESET_PC=0x1000, memory always ready with 1-cycle response -> requests 0x1000, 0x1008, ...; decode receives (instr@0x1000, npc 0x1004), then (instr@0x1004, npc 0x1008), in order.
REQ-041 Redirect to 0x2004 -> request addr 0x2000; only the upper word is enqueued, with npc 0x2008; the next request is 0x2008.
REQ-042 ID_stall=1 held for 10 cycles with QDEPTH=4 -> queue holds 4 entries, no request issued, IFID_instreg stable; on release, entries drain one per cycle in order.
REQ-043 Redirect to 0x3000 while in WAIT, response arrives 3 cycles later -> that data is dropped, next request is 0x3000, no stale instruction reaches decode.
REQ-044 Redirect in the same cycle as mem_resp_valid and a pop -> IFID_ready=0 next cycle, queue empty, next request is the redirect address.
REQ-045 Reset asserted during WAIT, then released -> request to RESET_PC; a late response arriving after reset is not enqueued.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests aligned doublewords from instruction memory and
// splits them into a small in-order instruction queue feeding decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [31:0] IFID_instreg,
  output logic [63:0] IFID_npc,
  output logic        IFID_ready,
  input  logic        ID_stall
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [QDEPTH];
  logic [63:0]   npc_mem_q   [QDEPTH];

  logic          not_empty_s, pop_s, take_s, lo_en_s;
  logic [1:0]    push_n_s;
  logic [CW-1:0] free_s;
  logic [PW-1:0] hi_idx_s;
  logic [60:0]   line_s, line_inc_s;

  // A response is only consumed in WAIT; a same-cycle redirect drops it.
  always_comb begin
    not_empty_s = (count_q != '0);
    pop_s       = not_empty_s & ~ID_stall;
    take_s      = (state_q == WAIT) & mem_resp_valid & ~redirect_valid;
    lo_en_s     = take_s & ~fetch_pc_q[2];
    push_n_s    = {1'b0, take_s} + {1'b0, lo_en_s};
    free_s      = QDEPTH_C - count_q + CW'(pop_s);
    hi_idx_s    = tail_q + PW'(lo_en_s);
    line_s      = fetch_pc_q[63:3];
    line_inc_s  = line_s + 61'd1;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q + PW'(pop_s);
    tail_d     = tail_q + PW'(push_n_s);
    count_d    = count_q + CW'(push_n_s) - CW'(pop_s);
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else if (take_s) begin
      fetch_pc_d = {line_inc_s, 3'b000};
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect that lands while a request is in flight must swallow its stale response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid || (free_s >= CW'(2))) state_d = REQ;
        else                                     state_d = IDLE;
      end
      REQ: begin
        if (mem_req_ready) state_d = redirect_valid ? DISCARD : WAIT;
        else               state_d = REQ;
      end
      WAIT: begin
        if (redirect_valid) state_d = mem_resp_valid ? REQ : DISCARD;
        else if (mem_resp_valid) state_d = IDLE;
        else state_d = WAIT;
      end
      DISCARD: begin
        if (mem_resp_valid) state_d = REQ;
        else                state_d = DISCARD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = 64'h0;
    IFID_ready    = 1'b0;
    IFID_instreg  = 32'h0;
    IFID_npc      = 64'h0;
    if (!reset && (state_q == REQ)) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = {line_s, 3'b000};
    end else begin
      mem_req_valid = 1'b0;
    end
    if (!reset && not_empty_s) begin
      IFID_ready   = 1'b1;
      IFID_instreg = instr_mem_q[head_q];
      IFID_npc     = npc_mem_q[head_q];
    end else begin
      IFID_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= {RESET_PC[63:2], 2'b00};
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Lower word goes in first so program order is kept when both halves are used.
  always_ff @(posedge clk) begin
    if (take_s) begin
      if (lo_en_s) begin
        instr_mem_q[tail_q] <= mem_resp_data[31:0];
        npc_mem_q[tail_q]   <= {line_s, 3'b100};
      end
      instr_mem_q[hi_idx_s] <= mem_resp_data[63:32];
      npc_mem_q[hi_idx_s]   <= {line_inc_s, 3'b000};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural memory pushes expected decode
// entries when it returns live data; decode pops are compared in order.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          QD     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] IFID_instreg;
  logic [63:0] IFID_npc;
  logic        IFID_ready;
  logic        ID_stall;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .IFID_instreg(IFID_instreg), .IFID_npc(IFID_npc), .IFID_ready(IFID_ready),
    .ID_stall(ID_stall)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] npc;
  } ent_t;

  ent_t        sb[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  logic [63:0] exp_pc;
  int          epoch = 0;
  logic        pend = 1'b0;
  logic        pend_rst = 1'b0;
  logic [63:0] pend_addr;
  int          pend_cnt, pend_epoch;
  int          resp_delay = 1;
  logic        drv_reset = 1'b1, drv_redirect = 1'b0, drv_stall = 1'b0;
  logic [63:0] drv_target = 64'h0;
  logic        ready_en = 1'b1, rnd_ready = 1'b0;
  int          cyc = 0, since_rst = 0, req_cnt = 0, pop_cnt = 0, acc_cyc = 0;
  logic        first_req_chk = 1'b0, chk_empty_next = 1'b0;
  logic        lat_arm_req = 1'b1, lat_armed = 1'b0;

  function automatic logic [31:0] instr_at(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, sample #1 later, advance the memory/scoreboard model.
  task automatic tick();
    logic        live;
    logic [63:0] w;
    ent_t        e;
    @(negedge clk);
    cyc++;
    reset          = drv_reset;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_target;
    ID_stall       = drv_stall;
    mem_req_ready  = rnd_ready ? ($urandom_range(0, 2) != 0) : ready_en;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 64'h0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = {instr_at(pend_addr + 64'd4), instr_at(pend_addr)};
      end else begin
        pend_cnt--;
      end
    end
    #1;
    if (reset) begin
      check_eq("rst_req_valid", 64'(mem_req_valid), 64'd0);
      check_eq("rst_req_addr", mem_req_addr, 64'd0);
      check_eq("rst_ifid_ready", 64'(IFID_ready), 64'd0);
      check_eq("rst_instreg", 64'(IFID_instreg), 64'd0);
      check_eq("rst_npc", IFID_npc, 64'd0);
      sb.delete();
      exp_pc = RST_PC;
      epoch++;
      since_rst = 0;
      first_req_chk = 1'b1;
      chk_empty_next = 1'b0;
      lat_armed = 1'b0;
      if (pend) pend_rst = 1'b1;
      if (mem_resp_valid) begin pend = 1'b0; pend_rst = 1'b0; end
      return;
    end
    since_rst++;
    if (chk_empty_next) begin
      check_eq("flush_empty", 64'(IFID_ready), 64'd0);
      chk_empty_next = 1'b0;
    end
    if (IFID_ready && lat_armed) begin
      check_eq("min_latency", 64'(cyc - acc_cyc), 64'd2);
      lat_armed = 1'b0;
    end
    if (IFID_ready && !ID_stall) begin
      pop_cnt++;
      check_eq("pop_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("instr", 64'(IFID_instreg), 64'(e.instr));
        check_eq("npc", IFID_npc, e.npc);
      end
    end
    if (mem_resp_valid) begin
      live = (pend_epoch == epoch) && !pend_rst && !redirect_valid;
      pend = 1'b0;
      pend_rst = 1'b0;
      if (live) begin
        for (int k = 0; k < 2; k++) begin
          w = pend_addr + 64'(4 * k);
          if (w >= exp_pc) sb.push_back('{instr: instr_at(w), npc: w + 64'd4});
        end
        exp_pc = pend_addr + 64'd8;
      end
    end
    if (mem_req_valid) begin
      req_cnt++;
      if (first_req_chk) begin
        check_eq("first_req_cycle", 64'(since_rst), 64'd2);
        first_req_chk = 1'b0;
      end
      check_eq("req_addr", mem_req_addr, {exp_pc[63:3], 3'b000});
      check_eq("one_outstanding", 64'(pend && !pend_rst), 64'd0);
      if (mem_req_ready) begin
        pend       = 1'b1;
        pend_rst   = 1'b0;
        pend_addr  = mem_req_addr;
        pend_cnt   = resp_delay;
        pend_epoch = epoch;
        if (lat_arm_req) begin
          acc_cyc = cyc;
          lat_armed = 1'b1;
          lat_arm_req = 1'b0;
        end
      end
    end
    if (redirect_valid) begin
      epoch++;
      exp_pc = {redirect_pc[63:2], 2'b00};
      sb.delete();
      chk_empty_next = 1'b1;
      lat_armed = 1'b0;
    end
  endtask

  initial begin
    int   r0, p0;
    logic found;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; ID_stall = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'h0;
    exp_pc = RST_PC;

    // Reset, then sequential fetch from RESET_PC with a 1-cycle memory.
    repeat (3) tick();
    drv_reset = 1'b0;
    repeat (30) tick();

    // Redirect to a mid-doubleword address: only the upper half is enqueued.
    drv_target = 64'h2004; drv_redirect = 1'b1; tick(); drv_redirect = 1'b0;
    repeat (15) tick();

    // Decode stall fills the queue; nothing more is requested.
    drv_target = 64'h4000; drv_redirect = 1'b1; drv_stall = 1'b1; tick(); drv_redirect = 1'b0;
    repeat (12) tick();
    r0 = req_cnt;
    repeat (10) tick();
    check_eq("stall_full", 64'(sb.size()), 64'(QD));
    check_eq("stall_ready", 64'(IFID_ready), 64'd1);
    check_eq("stall_head", 64'(IFID_instreg), 64'(instr_at(64'h4000)));
    check_eq("stall_no_req", 64'(req_cnt - r0), 64'd0);
    drv_stall = 1'b0;
    p0 = pop_cnt;
    repeat (4) tick();
    check_eq("drain_rate", 64'(pop_cnt - p0), 64'd4);
    repeat (6) tick();

    // Redirect while waiting on a slow response: the response must be dropped.
    resp_delay = 4;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = pend && !pend_rst && (pend_cnt == resp_delay);
    end
    check_eq("wait_found", 64'(found), 64'd1);
    drv_target = 64'h3000; drv_redirect = 1'b1; tick(); drv_redirect = 1'b0;
    resp_delay = 1;
    repeat (20) tick();

    // Redirect coinciding with a response and a pop.
    drv_stall = 1'b1; repeat (6) tick(); drv_stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (pend && pend_cnt <= 1 && sb.size() != 0) begin
        drv_target = 64'h5008; drv_redirect = 1'b1; found = 1'b1;
      end
      tick();
      drv_redirect = 1'b0;
    end
    check_eq("coincide_found", 64'(found), 64'd1);
    repeat (12) tick();

    // Random ready, stall, latency and redirects.
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      resp_delay   = $urandom_range(1, 3);
      drv_stall    = ($urandom_range(0, 9) < 3);
      drv_redirect = ($urandom_range(0, 11) == 0);
      drv_target   = 64'h6000 + 64'($urandom_range(0, 1023));
      tick();
    end
    drv_redirect = 1'b0; drv_stall = 1'b0; rnd_ready = 1'b0; ready_en = 1'b1;
    repeat (10) tick();

    // Reset during WAIT; the late response must not be enqueued.
    resp_delay = 4;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = pend && !pend_rst && (pend_cnt == resp_delay);
    end
    check_eq("wait_found_rst", 64'(found), 64'd1);
    tick();
    drv_reset = 1'b1; ready_en = 1'b0; tick(); drv_reset = 1'b0;
    for (int i = 0; i < 10 && pend; i++) tick();
    check_eq("late_resp_delivered", 64'(pend), 64'd0);
    resp_delay = 1; ready_en = 1'b1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
